// File: rtl/nearest_search_pkg.sv
// Shared types and helpers for the nearest-value search block.
package nearest_search_pkg;

    localparam int S     = 8;
    localparam int N_MAX = 16;
    localparam int CNT_W = $clog2(N_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Exact unsigned distance: always subtract the smaller from the larger.
    function automatic logic [S-1:0] abs_diff(input logic [S-1:0] a, input logic [S-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/nearest_search_dist_pick.sv
// Combinational distance compare: decides whether a candidate replaces the current best.
module nearest_search_dist_pick
    import nearest_search_pkg::*;
(
    input  logic [S-1:0] ref_val,
    input  logic [S-1:0] best_dist,
    input  logic [S-1:0] cand,
    input  logic         first,
    output logic         take,
    output logic [S-1:0] cand_dist
);

    assign cand_dist = abs_diff(cand, ref_val);
    // Strict less-than keeps the earlier index on a tie.
    assign take      = first | (cand_dist < best_dist);

endmodule

// File: rtl/nearest_search.sv
// Streams candidates, keeps the one closest to a latched reference and reports it.
// Optional out_dist port is enabled by defining NEAREST_SEARCH_DIST_EN.
module nearest_search
    import nearest_search_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [S-1:0]     ref_in,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [S-1:0]     in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    output logic [S-1:0]     out_data,
    output logic [CNT_W-1:0] out_index,
`ifdef NEAREST_SEARCH_DIST_EN
    output logic [S-1:0]     out_dist,
`endif
    input  logic             out_ready
);

    state_t           state_r;
    logic [S-1:0]     ref_r;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] rcv_cnt_r;
    logic [S-1:0]     best_data_r;
    logic [CNT_W-1:0] best_index_r;
    logic [S-1:0]     best_dist_r;
    logic [CNT_W-1:0] count_clamped_s;
    logic             take_s;
    logic [S-1:0]     cand_dist_s;

    nearest_search_dist_pick u_dist_pick (
        .ref_val   (ref_r),
        .best_dist (best_dist_r),
        .cand      (in_data),
        .first     (rcv_cnt_r == {CNT_W{1'b0}}),
        .take      (take_s),
        .cand_dist (cand_dist_s)
    );

    // Requests above the maximum are clamped rather than rejected.
    always_comb begin
        count_clamped_s = count;
        if (count > CNT_W'(N_MAX)) begin
            count_clamped_s = CNT_W'(N_MAX);
        end else begin
            count_clamped_s = count;
        end
    end

    // Search FSM with best-candidate tracking and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            ref_r        <= {S{1'b0}};
            target_r     <= {CNT_W{1'b0}};
            rcv_cnt_r    <= {CNT_W{1'b0}};
            best_data_r  <= {S{1'b0}};
            best_index_r <= {CNT_W{1'b0}};
            best_dist_r  <= {S{1'b0}};
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        ref_r       <= ref_in;
                        target_r    <= count_clamped_s;
                        rcv_cnt_r   <= {CNT_W{1'b0}};
                        best_data_r <= {S{1'b0}};
                        best_dist_r <= {S{1'b0}};
                        busy        <= 1'b1;
                        if (count == {CNT_W{1'b0}}) begin
                            best_index_r <= {CNT_W{1'b1}};
                            out_valid    <= 1'b1;
                            state_r      <= REPORT;
                        end else begin
                            best_index_r <= {CNT_W{1'b0}};
                            in_ready     <= 1'b1;
                            state_r      <= LOAD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        rcv_cnt_r <= rcv_cnt_r + CNT_W'(1);
                        if (take_s) begin
                            best_data_r  <= in_data;
                            best_index_r <= rcv_cnt_r;
                            best_dist_r  <= cand_dist_s;
                        end else begin
                            best_data_r  <= best_data_r;
                        end
                        if (rcv_cnt_r == target_r - CNT_W'(1)) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state_r   <= REPORT;
                        end else begin
                            state_r   <= LOAD;
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= REPORT;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = best_data_r;
    assign out_index = best_index_r;
`ifdef NEAREST_SEARCH_DIST_EN
    assign out_dist  = best_dist_r;
`endif

endmodule
